// File: rtl/panel_pkg.sv
// Shared definitions for the control-panel timer blocks.
package panel_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } timer_irq_state_t;

    localparam int LAMP_DIV_DEFAULT = 50;

endpackage

// File: rtl/timer_irq_if.sv
// Tick / acknowledge / status bundle between panel timer, interrupt system and timer_irq.
interface timer_irq_if #(
    parameter int OVF_WIDTH = 4
);
    logic                 zegar;
    logic                 irq_clr;
    logic                 ovf_clr;
    logic                 irq;
    logic [OVF_WIDTH-1:0] ovf;
    logic                 lamp;

    modport master (
        output zegar, irq_clr, ovf_clr,
        input  irq, ovf, lamp
    );

    modport slave (
        input  zegar, irq_clr, ovf_clr,
        output irq, ovf, lamp
    );
endinterface

// File: rtl/tick_div.sv
// Tick divider: toggles a registered output every DIV input ticks; reusable for panel blinkers.
module tick_div
    import panel_pkg::*;
#(
    parameter int DIV = LAMP_DIV_DEFAULT
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic tick,
    output logic out
);
    localparam int            CW   = $clog2(DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;
    logic          out_r;

    // Count ticks, wrap at DIV and flip the output on each wrap.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            cnt_r <= '0;
            out_r <= 1'b0;
        end else if (tick) begin
            if (cnt_r == LAST) begin
                cnt_r <= '0;
                out_r <= ~out_r;
            end else begin
                cnt_r <= cnt_r + CW'(1'b1);
            end
        end else begin
            cnt_r <= cnt_r;
            out_r <= out_r;
        end
    end

    assign out = out_r;

endmodule

// File: rtl/timer_irq.sv
// Clock-interrupt front end: tick-to-level request, lost-tick counter and clock lamp.
module timer_irq
    import panel_pkg::*;
#(
    parameter int OVF_WIDTH = 4,
    parameter int LAMP_DIV  = LAMP_DIV_DEFAULT
) (
    input  logic        clk_sys,
    input  logic        rst,
    timer_irq_if.slave  bus
);
    localparam logic [OVF_WIDTH-1:0] OVF_MAX = '1;

    timer_irq_state_t      state_r;
    logic [OVF_WIDTH-1:0]  ovf_r;
    logic [OVF_WIDTH-1:0]  ovf_nxt_s;
    logic                  lost_s;
    logic                  lamp_s;

    // A tick is lost only when it lands on a pending request that is not being acknowledged.
    always_comb begin
        lost_s    = (state_r == PEND) && bus.zegar && !bus.irq_clr;
        ovf_nxt_s = ovf_r;
        if (bus.ovf_clr) begin
            ovf_nxt_s = lost_s ? OVF_WIDTH'(1'b1) : '0;
        end else if (lost_s && (ovf_r != OVF_MAX)) begin
            ovf_nxt_s = ovf_r + OVF_WIDTH'(1'b1);
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // Request FSM and saturating lost-tick register; a same-cycle tick re-arms over an acknowledge.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_r <= IDLE;
            ovf_r   <= '0;
        end else begin
            ovf_r <= ovf_nxt_s;
            case (state_r)
                IDLE: begin
                    if (bus.zegar) begin
                        state_r <= PEND;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PEND: begin
                    if (bus.irq_clr && !bus.zegar) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= PEND;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    tick_div #(
        .DIV (LAMP_DIV)
    ) u_lamp_div (
        .clk_sys (clk_sys),
        .rst     (rst),
        .tick    (bus.zegar),
        .out     (lamp_s)
    );

    assign bus.irq  = (state_r == PEND);
    assign bus.ovf  = ovf_r;
    assign bus.lamp = lamp_s;

endmodule

// File: tb/tb_timer_irq.sv
// Scoreboard bench for timer_irq: two instances (narrow counter / DIV=3 and wide counter / DIV=1).
module tb_timer_irq;

    logic clk_sys = 1'b0;
    logic rst     = 1'b0;

    always #5 clk_sys = ~clk_sys;

    timer_irq_if #(.OVF_WIDTH(2)) if_a ();
    timer_irq_if #(.OVF_WIDTH(4)) if_b ();

    timer_irq #(.OVF_WIDTH(2), .LAMP_DIV(3)) dut_a (
        .clk_sys (clk_sys),
        .rst     (rst),
        .bus     (if_a)
    );

    timer_irq #(.OVF_WIDTH(4), .LAMP_DIV(1)) dut_b (
        .clk_sys (clk_sys),
        .rst     (rst),
        .bus     (if_b)
    );

    typedef struct packed {
        logic       irq;
        logic [1:0] ovf_a;
        logic [3:0] ovf_b;
        logic       lamp_a;
        logic       lamp_b;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model: pending flag, lost-tick counts, total ticks since reset.
    bit m_pend  = 1'b0;
    int m_ovf_a = 0;
    int m_ovf_b = 0;
    int m_ticks = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v, input int maxv);
        return (v + 1 > maxv) ? maxv : v + 1;
    endfunction

    task automatic cyc(input bit r, input bit z, input bit ic, input bit oc);
        exp_t e;
        bit   lost;
        @(negedge clk_sys);
        rst          = r;
        if_a.zegar   = z;  if_b.zegar   = z;
        if_a.irq_clr = ic; if_b.irq_clr = ic;
        if_a.ovf_clr = oc; if_b.ovf_clr = oc;
        if (r) begin
            m_pend  = 1'b0;
            m_ovf_a = 0;
            m_ovf_b = 0;
            m_ticks = 0;
        end else begin
            lost = m_pend && z && !ic;
            if (oc) begin
                m_ovf_a = lost ? 1 : 0;
                m_ovf_b = lost ? 1 : 0;
            end else if (lost) begin
                m_ovf_a = sat_inc(m_ovf_a, 3);
                m_ovf_b = sat_inc(m_ovf_b, 15);
            end
            if (z) begin
                m_pend = 1'b1;
                m_ticks++;
            end else if (ic) begin
                m_pend = 1'b0;
            end
        end
        e.irq    = m_pend;
        e.ovf_a  = 2'(m_ovf_a);
        e.ovf_b  = 4'(m_ovf_b);
        e.lamp_a = ((m_ticks / 3) % 2) == 1;
        e.lamp_b = (m_ticks % 2) == 1;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle the DUTs present fresh outputs; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_sys);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("irq_a",  int'(if_a.irq),  int'(e.irq));
                chk("irq_b",  int'(if_b.irq),  int'(e.irq));
                chk("ovf_a",  int'(if_a.ovf),  int'(e.ovf_a));
                chk("ovf_b",  int'(if_b.ovf),  int'(e.ovf_b));
                chk("lamp_a", int'(if_a.lamp), int'(e.lamp_a));
                chk("lamp_b", int'(if_b.lamp), int'(e.lamp_b));
            end
        end
    end

    initial begin
        if_a.zegar = 1'b0; if_a.irq_clr = 1'b0; if_a.ovf_clr = 1'b0;
        if_b.zegar = 1'b0; if_b.irq_clr = 1'b0; if_b.ovf_clr = 1'b0;

        // Reset, single tick, late acknowledge
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Overrun, acknowledge, clear
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Saturation, then clear together with a lost tick
        repeat (10) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);

        // Tick plus acknowledge while pending; acknowledge in idle
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Lamp: 7 ticks from reset with gaps
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (7) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        // Two more ticks: lamp_a flips only if the divider count resumed at 1
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0);

        // Reset in PEND with ovf=2, lamp=1 and a coincident tick
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic
        repeat (400) begin
            cyc($urandom_range(0, 99) == 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 9) == 0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Drain with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk_sys);
        #2;
        chk("drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/timer_irq.md
# timer_irq

Clock-interrupt front end for the control panel timer. Consumes the one-cycle `zegar` tick and turns it into a level interrupt request held until the interrupt system acknowledges it. Counts ticks lost while a request is still pending, and drives the panel's blinking clock lamp. Sits between the panel timer and the CPU interrupt system.

## Interface
Parameters:
- OVF_WIDTH, 4: width of the lost-tick counter; legal values are 1 or more.
- LAMP_DIV, 50: number of `zegar` ticks per lamp toggle; legal values are 1 or more (50 gives 1 Hz blink at a 10 ms tick).

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- zegar  in  1  timer tick; one-cycle pulse, already gated by the panel enable.
- irq_clr  in  1  one-cycle pulse from the interrupt system: clock interrupt accepted.
- ovf_clr  in  1  one-cycle pulse: clear the lost-tick counter.
- irq  out  1  clock interrupt request; level.
- ovf  out  OVF_WIDTH  lost-tick count; saturating.
- lamp  out  1  panel clock lamp; toggles every LAMP_DIV ticks.

## Operation
- Request FSM has two states: IDLE (irq=0) and PEND (irq=1). State is registered; `irq` decodes PEND directly.
- In IDLE:
  - `zegar` -> PEND.
  - `irq_clr` is ignored (a spurious acknowledge is harmless).
- In PEND:
  - `irq_clr` alone -> IDLE.
  - `zegar` alone -> stay in PEND; `ovf` increments.
  - `zegar` and `irq_clr` in the same cycle -> stay in PEND (the new tick re-arms the request); `ovf` does not increment.
- Lost-tick counter `ovf`:
  - Increments only in the PEND + `zegar` + no-`irq_clr` case.
  - Saturates at 2^OVF_WIDTH-1 and never wraps.
  - `ovf_clr` alone -> 0.
  - `ovf_clr` in the same cycle as an increment -> 1 (the clear applies first, then the lost tick is counted).
- Lamp divider:
  - Counter `lamp_cnt` is $clog2(LAMP_DIV+1) bits wide.
  - On each `zegar`: if `lamp_cnt` == LAMP_DIV-1, then `lamp_cnt` <= 0 and `lamp` toggles; otherwise `lamp_cnt` increments.
  - No change without `zegar`.
  - The divider runs independently of the FSM and of `irq_clr`.
  - LAMP_DIV=1 toggles `lamp` on every tick.
- `rst` has priority over every other input in the same cycle.

## Timing
- Reset values: state=IDLE, irq=0, ovf=0, lamp=0, lamp_cnt=0.
- `zegar` at cycle n -> `irq`=1 from cycle n+1.
- `irq_clr` at cycle n -> `irq`=0 from cycle n+1, unless re-armed by a `zegar` in the same cycle.
- `ovf` and `lamp` update one cycle after the causing input.
- All outputs come straight from registers; there is no combinational path from input to output.
- `zegar` is assumed to be at most one cycle high per event. If it is held high for several cycles, each high cycle counts as one tick.
- `rst` asserted mid-operation: on the next edge every register returns to its reset value; `irq` drops even if the request is pending.

## Structure
- Shared package `panel_pkg` holds:
  - typedef `timer_irq_state_t` {IDLE, PEND};
  - constant LAMP_DIV_DEFAULT = 50.
- The lamp divider becomes sub-module `tick_div`:
  - ports: clk_sys, rst, tick, out;
  - parameter DIV.
  - The same divider is reusable for other panel blinkers.
- The FSM and the saturating `ovf` counter stay in the top module.

## Test plan
1. Reset, then one `zegar` -> `irq`=1 on the next cycle. `irq_clr` 5 cycles later -> `irq`=0 the following cycle; `ovf`=0.
2. Overrun: 3 `zegar` pulses with no `irq_clr` -> `irq` stays 1 and `ovf`=2. Then `irq_clr` -> `irq`=0 and `ovf` holds at 2. Then `ovf_clr` -> `ovf`=0.
3. Saturation with OVF_WIDTH=2: 10 ticks while pending -> `ovf` stops at 3. `ovf_clr` in the same cycle as a further lost tick -> `ovf`=1.
4. `zegar` and `irq_clr` in the same cycle while in PEND -> `irq` stays 1 with no low cycle; `ovf` is unchanged. `irq_clr` in IDLE -> no change.
5. Lamp with LAMP_DIV=3: 7 ticks -> `lamp` toggles after tick 3 (to 1) and after tick 6 (to 0); `lamp_cnt`=1. With LAMP_DIV=1, every tick toggles `lamp`.
6. `rst` pulsed while in PEND with `ovf`=2 and `lamp`=1, with a `zegar` in the same cycle -> the next cycle shows `irq`=0, `ovf`=0, `lamp`=0.
